regfile_write_queue: RTL and testbench

//   Buffers write requests in a DEPTH-entry FIFO and drains them one per

---
 rtl/regfile_write_queue.sv | 118 +++++++++++
 tb/tb_regfile_write_queue.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: DEPTH-entry write buffer in front of register_files.
// Drains one entry per cycle and forwards the newest pending data on lookup.
module regfile_write_queue #(
  parameter int NUM_ADDRESS = 16,
  parameter int DATA_LENGTH = 32,
  parameter int DEPTH       = 4,
  localparam int ADDR_W = $clog2(NUM_ADDRESS),
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_address,
  input  logic [DATA_LENGTH-1:0] req_data,
  input  logic                   drain_enable,
  output logic                   write_enable,
  output logic [ADDR_W-1:0]      write_address,
  output logic [DATA_LENGTH-1:0] write_data_out,
  input  logic [ADDR_W-1:0]      lookup_address,
  output logic                   lookup_hit,
  output logic [DATA_LENGTH-1:0] lookup_data,
  output logic [CNT_W-1:0]       count
);

  logic [ADDR_W-1:0]      addr_q [DEPTH];
  logic [DATA_LENGTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]       vld_q;

  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;

  logic                   we_q;
  logic [ADDR_W-1:0]      waddr_q;
  logic [DATA_LENGTH-1:0] wdata_q;

  logic full;
  logic push;
  logic pop;

  // Full blocks a push even when a pop happens in the same cycle,
  // keeping req_ready free of any path from drain_enable.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign req_ready = !full && !reset;
  assign push      = req_valid && req_ready;
  assign pop       = drain_enable && (count_q != '0);

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, valid bits and the registered write port.
  // Push and pop never touch the same slot: pop needs count != 0
  // and push needs count != DEPTH, so the pointers differ.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        addr_q[wr_ptr_q] <= req_address;
        data_q[wr_ptr_q] <= req_data;
        vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        we_q            <= 1'b1;
        waddr_q         <= addr_q[rd_ptr_q];
        wdata_q         <= data_q[rd_ptr_q];
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
      end else begin
        we_q <= 1'b0;
      end
    end
  end

  // Forwarding: start from the in-flight output register, then scan
  // FIFO slots oldest to newest so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    if (we_q && (waddr_q == lookup_address)) begin
      lookup_hit  = 1'b1;
      lookup_data = wdata_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (vld_q[idx] && (addr_q[idx] == lookup_address)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end

  assign write_enable   = we_q;
  assign write_address  = waddr_q;
  assign write_data_out = wdata_q;
  assign count          = count_q;

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: scoreboard bench for regfile_write_queue.
// A cycle model tracks FIFO contents and the expected write port.
module tb_regfile_write_queue;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_address = '0;
  logic [DW-1:0] req_data = '0;
  logic          drain_enable = 1'b0;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data_out;
  logic [AW-1:0] lookup_address = '0;
  logic          lookup_hit;
  logic [DW-1:0] lookup_data;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  ent_t          sbq[$];
  int            mcount = 0;
  bit            we_exp = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;

  regfile_write_queue #(
    .NUM_ADDRESS(16),
    .DATA_LENGTH(DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_address(req_address),
    .req_data(req_data),
    .drain_enable(drain_enable),
    .write_enable(write_enable),
    .write_address(write_address),
    .write_data_out(write_data_out),
    .lookup_address(lookup_address),
    .lookup_hit(lookup_hit),
    .lookup_data(lookup_data),
    .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: accepted requests enter sbq, pops move the head
  // into the expected output register.
  always @(posedge clk) begin : model
    bit   acc;
    bit   pp;
    ent_t e;
    if (reset) begin
      sbq.delete();
      mcount   = 0;
      we_exp   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
    end else begin
      acc = req_valid && (mcount < DEPTH);
      pp  = drain_enable && (mcount != 0);
      if (pp) begin
        e        = sbq.pop_front();
        exp_addr = e.a;
        exp_data = e.d;
      end
      if (acc) sbq.push_back({req_address, req_data});
      we_exp = pp;
      mcount = mcount + int'(acc) - int'(pp);
    end
  end

  // Every cycle: write port, occupancy and ready against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (count !== CW'(mcount)) begin
        fails++;
        $display("FAIL mon_count got %0d want %0d", count, mcount);
      end
      tests++;
      if (write_enable !== we_exp) begin
        fails++;
        $display("FAIL mon_we got %b want %b", write_enable, we_exp);
      end
      tests++;
      if (write_address !== exp_addr || write_data_out !== exp_data) begin
        fails++;
        $display("FAIL mon_wport got %0d/%h want %0d/%h",
                 write_address, write_data_out, exp_addr, exp_data);
      end
      tests++;
      if (req_ready !== (!reset && mcount < DEPTH)) begin
        fails++;
        $display("FAIL mon_ready got %b want %b", req_ready,
                 (!reset && mcount < DEPTH));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b1;
    req_address = 4'd9;
    req_data = 32'h1234_5678;
    cyc();
    mon_en = 1'b1;
    cyc();
    tests++;
    if (req_ready !== 1'b0 || count !== '0) begin
      fails++;
      $display("FAIL reset_rdy_cnt got %b/%0d want 0/0", req_ready, count);
    end
    tests++;
    if (write_enable !== 1'b0 || write_address !== '0
        || write_data_out !== '0) begin
      fails++;
      $display("FAIL reset_wport got %b/%0d/%h want 0/0/0",
               write_enable, write_address, write_data_out);
    end
    tests++;
    if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
      fails++;
      $display("FAIL reset_lookup got %b/%h want 0/0",
               lookup_hit, lookup_data);
    end
    reset = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic test_single();
    drain_enable = 1'b1;
    req_valid = 1'b1;
    req_address = 4'd3;
    req_data = 32'hDEAD_BEEF;
    cyc();
    req_valid = 1'b0;
    tests++;
    if (count !== 3'd1 || write_enable !== 1'b0) begin
      fails++;
      $display("FAIL single_accept got cnt %0d we %b want 1/0",
               count, write_enable);
    end
    cyc();
    tests++;
    if (write_enable !== 1'b1 || write_address !== 4'd3
        || write_data_out !== 32'hDEAD_BEEF || count !== 3'd0) begin
      fails++;
      $display("FAIL single_pulse got %b/%0d/%h/%0d want 1/3/deadbeef/0",
               write_enable, write_address, write_data_out, count);
    end
    cyc();
    tests++;
    if (write_enable !== 1'b0) begin
      fails++;
      $display("FAIL single_end got we %b want 0", write_enable);
    end
  endtask

  task automatic test_fill();
    drain_enable = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      req_valid = 1'b1;
      req_address = AW'(i);
      req_data = 32'h100 + i;
      cyc();
    end
    tests++;
    if (count !== 3'd4 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_full got %0d/%b want 4/0", count, req_ready);
    end
    req_address = 4'd5;
    req_data = 32'h105;
    cyc();
    cyc();
    tests++;
    if (count !== 3'd4) begin
      fails++;
      $display("FAIL fill_hold got %0d want 4", count);
    end
    req_valid = 1'b0;
    drain_enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      tests++;
      if (write_enable !== 1'b1 || write_address !== AW'(i)
          || write_data_out !== 32'h100 + i) begin
        fails++;
        $display("FAIL fill_drain%0d got %b/%0d/%h want 1/%0d/%h", i,
                 write_enable, write_address, write_data_out,
                 i, 32'h100 + i);
      end
    end
    cyc();
    tests++;
    if (write_enable !== 1'b0 || count !== 3'd0) begin
      fails++;
      $display("FAIL fill_end got %b/%0d want 0/0", write_enable, count);
    end
  endtask

  task automatic test_forward();
    drain_enable = 1'b0;
    req_valid = 1'b1;
    req_address = 4'd6;
    req_data = 32'hDEAD_BABE;
    cyc();
    req_data = 32'hCAFE_F00D;
    cyc();
    req_valid = 1'b0;
    lookup_address = 4'd6;
    #1;
    tests++;
    if (lookup_hit !== 1'b1 || lookup_data !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL fwd_newest got %b/%h want 1/cafef00d",
               lookup_hit, lookup_data);
    end
    lookup_address = 4'd5;
    #1;
    tests++;
    if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
      fails++;
      $display("FAIL fwd_miss got %b/%h want 0/0", lookup_hit, lookup_data);
    end
    drain_enable = 1'b1;
    lookup_address = 4'd6;
    cyc();
    tests++;
    if (lookup_hit !== 1'b1 || lookup_data !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL fwd_over_oreg got %b/%h want 1/cafef00d",
               lookup_hit, lookup_data);
    end
    cyc();
    tests++;
    if (lookup_hit !== 1'b1 || lookup_data !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL fwd_oreg got %b/%h want 1/cafef00d",
               lookup_hit, lookup_data);
    end
    cyc();
    tests++;
    if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
      fails++;
      $display("FAIL fwd_idle got %b/%h want 0/0", lookup_hit, lookup_data);
    end
  endtask

  task automatic test_back_to_back();
    drain_enable = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_address = AW'(7 + i);
      req_data = 32'h200 + i;
      cyc();
    end
    drain_enable = 1'b1;
    for (int i = 2; i < 6; i++) begin
      req_address = AW'(7 + i);
      req_data = 32'h200 + i;
      cyc();
      tests++;
      if (count !== 3'd2 || write_enable !== 1'b1) begin
        fails++;
        $display("FAIL b2b_cnt%0d got %0d/%b want 2/1", i,
                 count, write_enable);
      end
    end
    req_valid = 1'b0;
    repeat (3) cyc();
    tests++;
    if (count !== 3'd0 || write_enable !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end got %0d/%b want 0/0", count, write_enable);
    end
  endtask

  task automatic test_reset_mid();
    drain_enable = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_address = AW'(12 + i);
      req_data = 32'h300 + i;
      cyc();
    end
    req_valid = 1'b0;
    tests++;
    if (count !== 3'd3) begin
      fails++;
      $display("FAIL rmid_pre got %0d want 3", count);
    end
    drain_enable = 1'b1;
    reset = 1'b1;
    lookup_address = 4'd12;
    cyc();
    tests++;
    if (count !== 3'd0 || write_enable !== 1'b0 || lookup_hit !== 1'b0) begin
      fails++;
      $display("FAIL rmid_after got %0d/%b/%b want 0/0/0",
               count, write_enable, lookup_hit);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests++;
      if (write_enable !== 1'b0) begin
        fails++;
        $display("FAIL rmid_ghost%0d got we %b want 0", i, write_enable);
      end
    end
  endtask

  task automatic test_random();
    ent_t          e;
    bit            hit;
    logic [DW-1:0] dat;
    for (int n = 0; n < 200; n++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      drain_enable = ($urandom_range(0, 4) < 3);
      req_address = AW'($urandom_range(0, 3));
      req_data = $urandom;
      lookup_address = AW'($urandom_range(0, 3));
      #1;
      hit = 1'b0;
      dat = '0;
      if (we_exp && exp_addr == lookup_address) begin
        hit = 1'b1;
        dat = exp_data;
      end
      foreach (sbq[k]) begin
        e = sbq[k];
        if (e.a == lookup_address) begin
          hit = 1'b1;
          dat = e.d;
        end
      end
      tests++;
      if (lookup_hit !== hit || lookup_data !== dat) begin
        fails++;
        $display("FAIL rnd_lookup%0d got %b/%h want %b/%h", n,
                 lookup_hit, lookup_data, hit, dat);
      end
      cyc();
    end
    req_valid = 1'b0;
    drain_enable = 1'b1;
    repeat (6) cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
